wallace_seq_mult8: RTL and testbench



---
 rtl/wallace_pkg.sv | 15 +
 rtl/wallace_seq_mult8_if.sv | 24 ++
 rtl/bit_4_carry_lookahead.sv | 24 ++
 rtl/wallace_pass_sel.sv | 17 +
 rtl/wallace_tree.sv | 38 +++
 rtl/wallace_seq_mult8.sv | 95 +++++++++
 tb/tb_wallace_seq_mult8.sv | 175 +++++++++++++++++
 7 files changed

// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - shared types and sizes for the sequential nibble multiplier
package wallace_pkg;

    localparam int NIB_W      = 4;
    localparam int OP_W       = 8;
    localparam int PROD_W     = 16;
    localparam int NUM_PASSES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wallace_seq_mult8_if.sv
// rtl/wallace_seq_mult8_if.sv - operand/product handshake bundle for wallace_seq_mult8
interface wallace_seq_mult8_if;
    import wallace_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;
    logic              pp_ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy, pp_ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy, pp_ovf
    );
endinterface

// File: rtl/bit_4_carry_lookahead.sv
// rtl/bit_4_carry_lookahead.sv - 4-bit carry-lookahead adder slice
module bit_4_carry_lookahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
endmodule

// File: rtl/wallace_pass_sel.sv
// rtl/wallace_pass_sel.sv - nibble and shift selection for each partial-product pass
module wallace_pass_sel
    import wallace_pkg::*;
(
    input  logic [1:0]       cnt,
    input  logic [OP_W-1:0]  a_q,
    input  logic [OP_W-1:0]  b_q,
    output logic [NIB_W-1:0] a_nib,
    output logic [NIB_W-1:0] b_nib,
    output logic [3:0]       shift
);
    assign a_nib = cnt[0] ? a_q[7:4] : a_q[3:0];
    assign b_nib = cnt[1] ? b_q[7:4] : b_q[3:0];

    // 4 * (cnt[0] + cnt[1]): the two-bit sum lands directly in shift[3:2]
    assign shift = {cnt[0] & cnt[1], cnt[0] ^ cnt[1], 2'b00};
endmodule

// File: rtl/wallace_tree.sv
// rtl/wallace_tree.sv - 4x4 unsigned Wallace multiplier with CLA final adder
module wallace_tree (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product,
    output logic       c_8
);
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] s1, c1, s2, c2;
    logic       c_4;

    assign r0 = {4'b0, a & {4{b[0]}}};
    assign r1 = {3'b0, a & {4{b[1]}}, 1'b0};
    assign r2 = {2'b0, a & {4{b[2]}}, 2'b0};
    assign r3 = {1'b0, a & {4{b[3]}}, 3'b0};

    // Two carry-save layers leave a sum/carry pair that a single ripple of CLAs resolves
    assign s1 = r0 ^ r1 ^ r2;
    assign c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    assign s2 = s1 ^ c1 ^ r3;
    assign c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;

    bit_4_carry_lookahead u_cla_lo (
        .a    (s2[3:0]),
        .b    (c2[3:0]),
        .cin  (1'b0),
        .sum  (product[3:0]),
        .cout (c_4)
    );

    bit_4_carry_lookahead u_cla_hi (
        .a    (s2[7:4]),
        .b    (c2[7:4]),
        .cin  (c_4),
        .sum  (product[7:4]),
        .cout (c_8)
    );
endmodule

// File: rtl/wallace_seq_mult8.sv
// rtl/wallace_seq_mult8.sv - 8x8 multiplier running four nibble passes through one 4x4 tree
module wallace_seq_mult8
    import wallace_pkg::*;
#(
    parameter bit HOLD_RESULT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    wallace_seq_mult8_if.slave   bus
);
    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [OP_W-1:0]   a_q, a_nxt;
    logic [OP_W-1:0]   b_q, b_nxt;
    logic [PROD_W-1:0] acc, acc_nxt;
    logic              ovf_q, ovf_nxt;

    logic [NIB_W-1:0]  a_nib, b_nib;
    logic [3:0]        shift;
    logic [7:0]        pp;
    logic              c_8;

    wallace_pass_sel u_pass_sel (
        .cnt   (cnt),
        .a_q   (a_q),
        .b_q   (b_q),
        .a_nib (a_nib),
        .b_nib (b_nib),
        .shift (shift)
    );

    wallace_tree u_tree (
        .a       (a_nib),
        .b       (b_nib),
        .product (pp),
        .c_8     (c_8)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            acc   <= acc_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        b_nxt     = b_q;
        acc_nxt   = acc;
        ovf_nxt   = ovf_q;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    a_nxt     = bus.a;
                    b_nxt     = bus.b;
                    acc_nxt   = '0;
                    cnt_nxt   = 2'd0;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                acc_nxt = acc + ({8'b0, pp} << shift);
                cnt_nxt = cnt + 2'd1;
                if (c_8) ovf_nxt = 1'b1;
                if (cnt == 2'(NUM_PASSES - 1)) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                    if (!HOLD_RESULT) acc_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == MUL) || (state == DONE);
    assign bus.product   = acc;
    assign bus.pp_ovf    = ovf_q;
endmodule

// File: tb/tb_wallace_seq_mult8.sv
// tb/tb_wallace_seq_mult8.sv - randomized self-checking bench for wallace_seq_mult8
module tb_wallace_seq_mult8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wallace_seq_mult8_if bus ();
    wallace_seq_mult8_if bus0 ();

    wallace_seq_mult8 #(.HOLD_RESULT(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    wallace_seq_mult8 #(.HOLD_RESULT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.in_valid  = bus.in_valid;
    assign bus0.a         = bus.a;
    assign bus0.b         = bus.b;
    assign bus0.out_ready = bus.out_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Presents an operand pair at a negedge and waits for out_valid; out_ready held low.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, output int lat);
        bus.a = ta;
        bus.b = tb;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
    endtask

    task automatic full_op(input string tag, input logic [7:0] ta, input logic [7:0] tb);
        int lat;
        start_op(ta, tb, lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_prod"}, bus.product, ref_mul(ta, tb));
        finish_op();
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] e;
        int lat;
        int cyc, last_acc, acc_cnt, done_cnt;
        logic [7:0] ra, rb;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_product", bus.product, 0);
        chk("rst_pp_ovf", bus.pp_ovf, 0);

        // rst beats in_valid on the same edge
        bus.in_valid = 1'b1;
        bus.a = 8'h11;
        bus.b = 8'h22;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_vs_valid_busy", bus.busy, 0);
        chk("rst_vs_valid_ready", bus.in_ready, 1);

        full_op("t1", 8'h12, 8'h34);
        full_op("t2", 8'hFF, 8'hFF);
        chk("t2_ovf", bus.pp_ovf, 0);

        full_op("t3a", 8'h80, 8'h02);
        chk("t3_hold1", bus.product, 16'h0100);
        chk("t3_hold0", bus0.product, 16'h0000);
        full_op("t3b", 8'h00, 8'hAB);
        chk("t3b_hold1", bus.product, 16'h0000);

        // Result must sit still while the consumer stalls, whatever the inputs do
        start_op(8'h0F, 8'hF0, lat);
        chk("t4_lat", lat, 4);
        for (int i = 0; i < 10; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.in_valid = 1'($urandom);
            @(negedge clk);
            chk("t4_valid", bus.out_valid, 1);
            chk("t4_prod", bus.product, 16'h0E10);
        end
        bus.in_valid = 1'b0;
        finish_op();

        // Abort mid-operation
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_product", bus.product, 0);
        chk("t5_in_ready", bus.in_ready, 1);
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_valid", bus.out_valid, 0);
        end
        full_op("t5b", 8'h03, 8'h05);

        // Back-to-back random stream
        cyc = 0;
        last_acc = -1;
        acc_cnt = 0;
        done_cnt = 0;
        bus.out_ready = 1'b1;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.in_valid = 1'b1;
        while (done_cnt < 20 && cyc < 400) begin
            if (bus.out_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("b2b_prod", bus.product, e);
                end else begin
                    chk("b2b_unexpected", 1, 0);
                end
                done_cnt++;
            end
            ra = bus.a;
            rb = bus.b;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mul(ra, rb));
                if (last_acc >= 0) chk("b2b_ii", cyc - last_acc, 6);
                last_acc = cyc;
                acc_cnt++;
                @(negedge clk);
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
                if (acc_cnt == 20) bus.in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            cyc++;
        end
        chk("b2b_done", done_cnt, 20);
        chk("b2b_accepted", acc_cnt, 20);
        chk("final_ovf", bus.pp_ovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
